// File: rtl/cs_overwrite_pipe.sv
// cs_overwrite_pipe: registered control-store overwrite stage.
//
// Collects x86 prefix bytes into per-instruction prefix state. On each accepted
// instruction it rewrites the operand-size, ModRM and segment fields of the
// selected control-store word, then queues the result in an output FIFO.
//
// Optional feature (macro CS_OVR_STATS_EN): saturating per-override event
// counters stat_size / stat_mod / stat_seg, cleared by reset only.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   flush               synchronous flush of FIFO and prefix state
//   pref_valid/byte     prefix byte input
//   in_valid/in_ready   instruction handshake (cw_in, B2, B3)
//   out_valid/ready     FIFO head handshake (cw_out, is_rep_out, pref_ovf_out)
//   stat_*              override event counters (CS_OVR_STATS_EN only)

module cs_overwrite_pipe #(
  parameter int unsigned CW_W       = 227,
  parameter int unsigned NSEG       = 6,
  parameter int unsigned MAXPREF    = 4,
  parameter int unsigned OBUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            pref_valid,
  input  logic [7:0]      pref_byte,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [CW_W-1:0] cw_in,
  input  logic [7:0]      B2,
  input  logic [7:0]      B3,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CW_W-1:0] cw_out,
  output logic            is_rep_out,
  output logic            pref_ovf_out
`ifdef CS_OVR_STATS_EN
  ,
  output logic [15:0]     stat_size,
  output logic [15:0]     stat_mod,
  output logic [15:0]     stat_seg
`endif
);

  // csAdapter field layout inside the control-store word.
  localparam int unsigned SizeLo      = 0;   // [1:0]
  localparam int unsigned IsModBit    = 2;
  localparam int unsigned IsDoubleBit = 3;
  localparam int unsigned M1RwLo      = 4;   // [5:4]
  localparam int unsigned R2Lo        = 6;   // [8:6]
  localparam int unsigned S3Lo        = 9;   // [11:9]
  localparam int unsigned R1Lo        = 12;  // [14:12]
  localparam int unsigned S3ModOvrBit = 15;
  localparam int unsigned R1ModOvrBit = 16;
  localparam int unsigned OpModOvrLo  = 17;  // [18:17]
  localparam int unsigned S1Lo        = 19;  // [21:19]
  localparam int unsigned Dest1Lo     = 22;  // [34:22]
  localparam int unsigned Op1Lo       = 35;  // [47:35]
  localparam int unsigned Dest2Lo     = 48;  // [60:48]
  localparam int unsigned Op2Lo       = 61;  // [73:61]

  localparam int unsigned CntW = $clog2(MAXPREF + 2);
  localparam int unsigned AW   = $clog2(OBUF_DEPTH);
  localparam logic [CntW-1:0] CntSat  = CntW'(MAXPREF + 1);
  localparam logic [CntW-1:0] PrefMax = CntW'(MAXPREF);

  // ---------------------------------------------------------------------------
  // Prefix decode and accumulation
  // ---------------------------------------------------------------------------
  logic            rep_q, rep_d, size_q, size_d, seg_q, seg_d;
  logic [NSEG-1:0] seg_sel_q, seg_sel_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic            dec_rep, dec_size, dec_seg, dec_hit;
  logic [NSEG-1:0] dec_seg_sel;

  always_comb begin
    dec_rep     = 1'b0;
    dec_size    = 1'b0;
    dec_seg     = 1'b0;
    dec_seg_sel = '0;
    if (pref_valid) begin
      unique case (pref_byte)
        8'hF2, 8'hF3: dec_rep  = 1'b1;
        8'h66:        dec_size = 1'b1;
        8'h26: begin dec_seg = 1'b1; dec_seg_sel[0] = 1'b1; end
        8'h2E: begin dec_seg = 1'b1; dec_seg_sel[1] = 1'b1; end
        8'h36: begin dec_seg = 1'b1; dec_seg_sel[2] = 1'b1; end
        8'h3E: begin dec_seg = 1'b1; dec_seg_sel[3] = 1'b1; end
        8'h64: begin dec_seg = 1'b1; dec_seg_sel[4] = 1'b1; end
        8'h65: begin dec_seg = 1'b1; dec_seg_sel[5] = 1'b1; end
        default: ;
      endcase
    end
    dec_hit = dec_rep | dec_size | dec_seg;
  end

  // Effective prefix state includes a prefix arriving in the accept cycle.
  logic            rep_eff, size_eff, seg_eff, ovf_eff;
  logic [NSEG-1:0] seg_sel_eff;
  logic [CntW-1:0] cnt_eff;

  always_comb begin
    rep_eff     = rep_q | dec_rep;
    size_eff    = size_q | dec_size;
    seg_eff     = seg_q | dec_seg;
    seg_sel_eff = dec_seg ? dec_seg_sel : seg_sel_q;
    cnt_eff     = (dec_hit && (cnt_q != CntSat)) ? cnt_q + 1'b1 : cnt_q;
    ovf_eff     = cnt_eff > PrefMax;
  end

  logic full, empty, accept, pop;

  assign in_ready = ~full;
  assign accept   = in_valid & in_ready & ~flush;
  assign pop      = out_valid & out_ready & ~flush;

  always_comb begin
    rep_d     = rep_q;
    size_d    = size_q;
    seg_d     = seg_q;
    seg_sel_d = seg_sel_q;
    cnt_d     = cnt_q;
    if (flush || accept) begin
      rep_d     = 1'b0;
      size_d    = 1'b0;
      seg_d     = 1'b0;
      seg_sel_d = '0;
      cnt_d     = '0;
    end else if (dec_hit) begin
      rep_d     = rep_eff;
      size_d    = size_eff;
      seg_d     = seg_eff;
      seg_sel_d = seg_sel_eff;
      cnt_d     = cnt_eff;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rep_q     <= 1'b0;
      size_q    <= 1'b0;
      seg_q     <= 1'b0;
      seg_sel_q <= '0;
      cnt_q     <= '0;
    end else begin
      rep_q     <= rep_d;
      size_q    <= size_d;
      seg_q     <= seg_d;
      seg_sel_q <= seg_sel_d;
      cnt_q     <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Field overrides
  // ---------------------------------------------------------------------------
  logic [7:0]      modrm;
  logic            is_mod, mod3, size_fire, seg_fire;
  logic [2:0]      seg_idx;
  logic [CW_W-1:0] cw_ovr;

  always_comb begin
    seg_idx = '0;
    for (int unsigned i = 0; i < NSEG; i++) begin
      if (seg_sel_eff[i]) seg_idx = 3'(i);
    end
  end

  always_comb begin
    modrm     = cw_in[IsDoubleBit] ? B3 : B2;
    is_mod    = cw_in[IsModBit];
    mod3      = is_mod & modrm[7] & modrm[6];
    size_fire = size_eff & (cw_in[SizeLo +: 2] == 2'b10);
    seg_fire  = is_mod & seg_eff;

    cw_ovr = cw_in;
    if (size_fire) cw_ovr[SizeLo +: 2] = 2'b01;
    if (mod3) begin
      cw_ovr[M1RwLo +: 2] = 2'b00;
      cw_ovr[R2Lo +: 3]   = modrm[2:0];
      if (cw_in[S3ModOvrBit]) cw_ovr[S3Lo +: 3] = modrm[5:3];
      if (cw_in[R1ModOvrBit]) cw_ovr[R1Lo +: 3] = modrm[5:3];
    end
    if (cw_in[Dest1Lo + 8] && cw_in[OpModOvrLo]) begin
      cw_ovr[Dest1Lo +: 13] = 13'h0002;
      cw_ovr[Op1Lo +: 13]   = 13'h0002;
    end
    if (cw_in[Dest2Lo + 8] && cw_in[OpModOvrLo + 1]) begin
      cw_ovr[Dest2Lo +: 13] = 13'h0002;
      cw_ovr[Op2Lo +: 13]   = 13'h0002;
    end
    if (seg_fire) cw_ovr[S1Lo +: 3] = seg_idx;
  end

  // ---------------------------------------------------------------------------
  // Output FIFO; pointers carry one extra wrap bit to tell full from empty.
  // ---------------------------------------------------------------------------
  logic [CW_W-1:0] mem_cw_q  [OBUF_DEPTH];
  logic            mem_rep_q [OBUF_DEPTH];
  logic            mem_ovf_q [OBUF_DEPTH];
  logic [AW:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (accept) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)    rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < OBUF_DEPTH; i++) begin
        mem_cw_q[i]  <= '0;
        mem_rep_q[i] <= 1'b0;
        mem_ovf_q[i] <= 1'b0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (accept) begin
        mem_cw_q[wr_ptr_q[AW-1:0]]  <= cw_ovr;
        mem_rep_q[wr_ptr_q[AW-1:0]] <= rep_eff;
        mem_ovf_q[wr_ptr_q[AW-1:0]] <= ovf_eff;
      end
    end
  end

  // Outputs read as zero whenever the FIFO is empty.
  always_comb begin
    out_valid    = ~empty;
    cw_out       = '0;
    is_rep_out   = 1'b0;
    pref_ovf_out = 1'b0;
    if (!empty) begin
      cw_out       = mem_cw_q[rd_ptr_q[AW-1:0]];
      is_rep_out   = mem_rep_q[rd_ptr_q[AW-1:0]];
      pref_ovf_out = mem_ovf_q[rd_ptr_q[AW-1:0]];
    end
  end

`ifdef CS_OVR_STATS_EN
  // ---------------------------------------------------------------------------
  // Saturating override counters; flush deliberately leaves them alone.
  // ---------------------------------------------------------------------------
  logic [15:0] stat_size_q, stat_size_d, stat_mod_q, stat_mod_d, stat_seg_q, stat_seg_d;

  always_comb begin
    stat_size_d = stat_size_q;
    stat_mod_d  = stat_mod_q;
    stat_seg_d  = stat_seg_q;
    if (accept) begin
      if (size_fire && (stat_size_q != 16'hFFFF)) stat_size_d = stat_size_q + 16'd1;
      if (mod3 && (stat_mod_q != 16'hFFFF))       stat_mod_d  = stat_mod_q + 16'd1;
      if (seg_fire && (stat_seg_q != 16'hFFFF))   stat_seg_d  = stat_seg_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_size_q <= '0;
      stat_mod_q  <= '0;
      stat_seg_q  <= '0;
    end else begin
      stat_size_q <= stat_size_d;
      stat_mod_q  <= stat_mod_d;
      stat_seg_q  <= stat_seg_d;
    end
  end

  assign stat_size = stat_size_q;
  assign stat_mod  = stat_mod_q;
  assign stat_seg  = stat_seg_q;
`endif

endmodule

// File: doc/cs_overwrite_pipe.md
Name: cs_overwrite_pipe

Overview:
- Registered, parametrised successor to the decode-stage control-store overwrite logic.
- Collects x86 prefix bytes over one or more cycles into per-instruction prefix state.
- Applies operand-size, ModRM and segment overrides to the selected control-store word, then queues the result in an output FIFO with valid/ready handshakes on both sides.
- Sits between control-store selection and the operand-fetch/address-generation stage.

Parameters:
CW_W, 227, width of the raw control-store word; fields are split by the existing csAdapter layout.
NSEG, 6, number of segment registers; width of the one-hot segment select.
MAXPREF, 4, maximum legal prefix bytes per instruction.
OBUF_DEPTH, 2, output FIFO entries (power of two, at least 2).

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
flush  in  1  synchronous pipeline flush
pref_valid  in  1  prefix byte present
pref_byte  in  8  prefix byte
in_valid  in  1  instruction control word present
in_ready  out  1  block can accept an instruction
cw_in  in  CW_W  selected control-store word
B2, B3  in  8 each  candidate ModRM bytes
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer takes head
cw_out  out  CW_W  control word with overridden fields rewritten in place
is_rep_out  out  1  REP/REPNE prefix seen
pref_ovf_out  out  1  more than MAXPREF prefixes seen for this instruction

Behaviour:
- Reset (rst=0, asynchronous):
  - Prefix state, prefix count and FIFO pointers are cleared.
  - out_valid=0, cw_out=0, is_rep_out=0, pref_ovf_out=0.
  - in_ready=1 once rst is deasserted.
- Prefix decode, accepted whenever pref_valid=1:
  - F2 or F3 sets rep.
  - 66 sets size.
  - 26, 2E, 36, 3E, 64, 65 set seg and load seg_sel one-hot to ES, CS, SS, DS, FS, GS (bits 0 to 5). The last segment prefix wins.
  - Any other byte is ignored and not counted.
- Prefix counting:
  - The count saturates at MAXPREF+1.
  - Count greater than MAXPREF sets ovf.
- Instruction accept:
  - Accept when in_valid and in_ready.
  - A prefix presented in the same cycle as the accept belongs to that instruction.
  - On accept, prefix state and count clear in the next cycle.
  - A prefix arriving while in_valid is held and in_ready=0 still accumulates.
- Override rules, combinational on the accept cycle and applied to the csAdapter fields:
  - m = isDouble ? B3 : B2; mod3 = isMOD & m[7] & m[6].
  - size: forced to 01 if size prefix and field size==10.
  - M1_RW: forced to 00 if mod3.
  - R2: set to m[2:0] if mod3.
  - S3: set to m[5:3] if mod3 & S3_MOD_OVR.
  - R1: set to m[5:3] if mod3 & R1_MOD_OVR.
  - dest1_mux and op1_mux: forced to 13'h0002 if dest1_mux[8] & OP_MOD_OVR[0]. Both are gated by dest1_mux[8].
  - dest2_mux and op2_mux: forced to 13'h0002 if dest2_mux[8] & OP_MOD_OVR[1].
  - S1: set to the binary index of seg_sel if isMOD & seg.
  - All other bits pass through unchanged.
- Output FIFO:
  - The rewritten word, rep and ovf are pushed on accept.
  - Latency is 1 cycle: data accepted at edge N appears with out_valid=1 after edge N.
  - in_ready = !full, with no combinational path from out_ready.
  - Pop on out_valid & out_ready.
  - Simultaneous push and pop is legal whenever not full.
  - Pointers wrap modulo OBUF_DEPTH.
  - Order is strictly preserved.
  - cw_out is held stable while out_valid=1 and out_ready=0.
- Flush:
  - Has priority over push, pop and prefix capture.
  - Clears the FIFO and prefix state in the next cycle; out_valid=0 after the edge.
- Reset mid-operation discards all queued entries.

Optional Feature:
- Macro: CS_OVR_STATS_EN.
- When defined, adds output ports stat_size[15:0], stat_mod[15:0] and stat_seg[15:0]. Each is a saturating counter (stops at 16'hFFFF), incremented on each accepted instruction where that override fired.
- The counters are cleared by reset only, not by flush.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then pref 66 and accept cw with size=10, isMOD=0 -> one cycle later out_valid=1, size field=01, all other bits equal cw_in.
- isMOD=1, isDouble=1, B3=8'hD9, R1_MOD_OVR=1, S3_MOD_OVR=1 -> R1=3, S3=3, R2=1, M1_RW=00; repeat with B3=8'h59 -> no change.
- Prefixes 2E then 64, isMOD=1 -> S1=4; with isMOD=0 -> S1 unchanged; the next instruction without prefixes -> S1 unchanged.
- Five prefixes (F3, 66, 26, 2E, 66) with MAXPREF=4 -> pref_ovf_out=1, is_rep_out=1; the following instruction -> both 0.
- Hold out_ready=0 and push 3 instructions with OBUF_DEPTH=2 -> in_ready=0 after 2; release -> 3 entries out in order with no loss or duplication.
- Assert flush with 2 entries queued and a prefix pending -> out_valid=0 next cycle and the next instruction is unmodified; with CS_OVR_STATS_EN, stat_size is unchanged by the flush.
